// File: rtl/imem_boot_loader.sv
// Boot loader: takes a length-prefixed byte stream, packs big-endian words into
// instruction memory from address 0, and keeps the core in reset until the image is written.
module imem_boot_loader #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    output logic                  s_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_reset,
    output logic                  done,
    output logic                  error
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    // state     | meaning
    // ST_LEN_HI | waiting for header high byte
    // ST_LEN_LO | waiting for header low byte, then range check
    // ST_DATA   | packing payload bytes, one write per 4 bytes
    // ST_FLUSH  | last write pulse on the bus, stream closed
    // ST_DONE   | image loaded, core released
    // ST_ERROR  | header too large, core held in reset
    typedef enum logic [2:0] {
        ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_FLUSH, ST_DONE, ST_ERROR
    } state_t;

    state_t                state_q;
    logic                  ready_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic                  core_reset_q;
    logic                  done_q;
    logic                  error_q;
    logic [7:0]            len_hi_q;
    logic [ADDR_WIDTH:0]   words_q;
    logic [ADDR_WIDTH:0]   word_idx_q;
    logic [ADDR_WIDTH:0]   word_idx_d;
    logic [1:0]            byte_idx_q;
    logic [23:0]           asm_q;
    logic [15:0]           hdr_n;
    logic                  xfer;

    assign xfer       = s_valid & ready_q;
    assign hdr_n      = {len_hi_q, s_data};
    assign word_idx_d = word_idx_q + 1'b1;

    // ready is registered and decoded from the next state, so it never follows s_valid
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_LEN_HI;
            ready_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            len_hi_q     <= '0;
            words_q      <= '0;
            word_idx_q   <= '0;
            byte_idx_q   <= '0;
            asm_q        <= '0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                ST_LEN_HI: begin
                    ready_q <= 1'b1;
                    if (xfer) begin
                        len_hi_q <= s_data;
                        state_q  <= ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (xfer) begin
                        if (hdr_n == 16'd0) begin
                            state_q      <= ST_DONE;
                            ready_q      <= 1'b0;
                            done_q       <= 1'b1;
                            core_reset_q <= 1'b0;
                        end else if (hdr_n > 16'(DEPTH)) begin
                            state_q <= ST_ERROR;
                            ready_q <= 1'b0;
                            error_q <= 1'b1;
                        end else begin
                            state_q    <= ST_DATA;
                            words_q    <= hdr_n[ADDR_WIDTH:0];
                            word_idx_q <= '0;
                            byte_idx_q <= '0;
                        end
                    end
                end
                ST_DATA: begin
                    if (xfer) begin
                        byte_idx_q <= byte_idx_q + 2'd1;
                        asm_q      <= {asm_q[15:0], s_data};
                        if (byte_idx_q == 2'd3) begin
                            we_q       <= 1'b1;
                            addr_q     <= word_idx_q[ADDR_WIDTH-1:0];
                            wdata_q    <= {asm_q, s_data};
                            word_idx_q <= word_idx_d;
                            if (word_idx_d == words_q) begin
                                state_q <= ST_FLUSH;
                                ready_q <= 1'b0;
                            end
                        end
                    end
                end
                ST_FLUSH: begin
                    state_q      <= ST_DONE;
                    done_q       <= 1'b1;
                    core_reset_q <= 1'b0;
                end
                default: begin
                    state_q <= state_q;
                end
            endcase
        end
    end

    assign s_ready    = ready_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign core_reset = core_reset_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: table of image shapes with random payloads,
// checked against a word-packing model, plus reset and post-done sequences.
module tb_imem_boot_loader;
    localparam int AW    = 6;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          s_valid = 1'b0;
    logic [7:0]    s_data = 8'h00;
    logic          s_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_reset;
    logic          done;
    logic          error;

    imem_boot_loader #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          addr;
        logic [31:0] data;
        logic        cr;
    } wr_t;

    typedef struct {
        int n;
        int gap;
        bit fixed;
        bit exp_done;
        bit exp_error;
        int exp_nwr;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cyc = -1;
    int   err_cyc = -1;
    wr_t  wr_q[$];
    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (imem_we === 1'b1)
            wr_q.push_back('{cyc, int'(imem_addr), imem_wdata, core_reset});
        if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
        if (error === 1'b1 && err_cyc < 0) err_cyc = cyc;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        s_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        wr_q.delete();
        done_cyc = -1;
        err_cyc  = -1;
    endtask

    // acc is the cycle in which the byte was presented and taken at its closing edge
    task automatic send_byte(input logic [7:0] b, input int gap, output int acc);
        logic ready_now;
        int   acc_c;
        acc = -1;
        repeat (gap) begin
            s_valid = 1'b0;
            s_data  = 8'($urandom);
            tick();
        end
        s_valid = 1'b1;
        s_data  = b;
        for (int k = 0; k < 20 && acc < 0; k++) begin
            ready_now = s_ready;
            acc_c     = cyc;
            tick();
            if (ready_now) acc = acc_c;
        end
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        if (acc < 0) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic post_offer(input string tag);
        int   nwr_before;
        logic d0, e0;
        nwr_before = wr_q.size();
        d0 = done;
        e0 = error;
        s_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s_data = 8'($urandom);
            check({tag, " post_ready"}, 32'(s_ready), 32'd0);
            tick();
        end
        s_valid = 1'b0;
        check({tag, " post_no_we"}, wr_q.size(), nwr_before);
        check({tag, " post_done"}, 32'(done), 32'(d0));
        check({tag, " post_error"}, 32'(error), 32'(e0));
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [7:0]  img[$];
        int          acc[$];
        logic [15:0] nn;
        int          nw, sent, last, a, g;
        logic [31:0] exp_w;
        string       tag;
        tag = $sformatf("v%0d", idx);
        nn  = 16'(v.n);
        img.push_back(nn[15:8]);
        img.push_back(nn[7:0]);
        nw   = (v.n == 0 || v.n > DEPTH) ? 0 : v.n;
        sent = 2 + 4 * nw;
        if (v.fixed) begin
            img.push_back(8'h20); img.push_back(8'h02); img.push_back(8'h00); img.push_back(8'h05);
            img.push_back(8'h20); img.push_back(8'h03); img.push_back(8'h00); img.push_back(8'h02);
        end else begin
            for (int i = 0; i < 4 * nw; i++) img.push_back(8'($urandom));
        end
        do_reset();
        for (int i = 0; i < sent; i++) begin
            g = (v.gap < 0) ? int'($urandom_range(0, 3)) : v.gap;
            send_byte(img[i], g, a);
            acc.push_back(a);
        end
        last = acc[sent-1];
        repeat (3) tick();
        check({tag, " write_count"}, wr_q.size(), v.exp_nwr);
        for (int i = 0; i < nw && i < wr_q.size(); i++) begin
            exp_w = {img[2+4*i], img[3+4*i], img[4+4*i], img[5+4*i]};
            check($sformatf("%s w%0d addr", tag, i), wr_q[i].addr, i);
            check($sformatf("%s w%0d data", tag, i), wr_q[i].data, exp_w);
            check($sformatf("%s w%0d cycle", tag, i), wr_q[i].cyc, acc[5+4*i] + 1);
            check($sformatf("%s w%0d core_reset", tag, i), 32'(wr_q[i].cr), 32'd1);
        end
        if (v.fixed && v.gap == 0 && wr_q.size() == 2) begin
            check({tag, " fixed_w0"}, wr_q[0].data, 32'h20020005);
            check({tag, " fixed_w1"}, wr_q[1].data, 32'h20030002);
        end
        check({tag, " done"}, 32'(done), 32'(v.exp_done));
        check({tag, " error"}, 32'(error), 32'(v.exp_error));
        check({tag, " core_reset"}, 32'(core_reset), v.exp_done ? 32'd0 : 32'd1);
        check({tag, " s_ready"}, 32'(s_ready), 32'd0);
        if (v.exp_done)
            check({tag, " done_cycle"}, done_cyc, (nw == 0) ? last + 1 : last + 2);
        if (v.exp_error)
            check({tag, " error_cycle"}, err_cyc, last + 1);
        post_offer(tag);
    endtask

    task automatic reset_outputs_check(input string tag);
        check({tag, " s_ready"}, 32'(s_ready), 32'd0);
        check({tag, " imem_we"}, 32'(imem_we), 32'd0);
        check({tag, " imem_addr"}, 32'(imem_addr), 32'd0);
        check({tag, " imem_wdata"}, imem_wdata, 32'd0);
        check({tag, " core_reset"}, 32'(core_reset), 32'd1);
        check({tag, " done"}, 32'(done), 32'd0);
        check({tag, " error"}, 32'(error), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] mid[$];
        logic [7:0] reload[$];
        int         a, last;

        vecs[0] = '{2,   0, 1'b1, 1'b1, 1'b0, 2};
        vecs[1] = '{2,   3, 1'b1, 1'b1, 1'b0, 2};
        vecs[2] = '{0,   0, 1'b0, 1'b1, 1'b0, 0};
        vecs[3] = '{64,  0, 1'b0, 1'b1, 1'b0, 64};
        vecs[4] = '{65,  0, 1'b0, 1'b0, 1'b1, 0};
        vecs[5] = '{1,  -1, 1'b0, 1'b1, 1'b0, 1};
        vecs[6] = '{5,  -1, 1'b0, 1'b1, 1'b0, 5};
        vecs[7] = '{256, 0, 1'b0, 1'b0, 1'b1, 0};
        vecs[8] = '{63, -1, 1'b0, 1'b1, 1'b0, 63};

        reset   = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hA5;
        tick();
        reset_outputs_check("rst1");
        tick();
        reset_outputs_check("rst2");
        s_valid = 1'b0;
        reset   = 1'b0;
        tick();
        check("rst_release s_ready", 32'(s_ready), 32'd1);
        check("rst_release core_reset", 32'(core_reset), 32'd1);

        for (int v = 0; v < 9; v++) run_vec(vecs[v], v);

        // reset in the middle of word 1 of a 4-word image, then a fresh 1-word image
        mid = '{8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        do_reset();
        foreach (mid[i]) send_byte(mid[i], 0, a);
        reset = 1'b1;
        tick();
        check("mid_rst core_reset", 32'(core_reset), 32'd1);
        check("mid_rst s_ready", 32'(s_ready), 32'd0);
        check("mid_rst done", 32'(done), 32'd0);
        reset = 1'b0;
        tick();
        check("mid_rst release s_ready", 32'(s_ready), 32'd1);
        check("mid_rst write_count", wr_q.size(), 1);
        if (wr_q.size() > 0) begin
            check("mid_rst w0 addr", wr_q[0].addr, 0);
            check("mid_rst w0 data", wr_q[0].data, 32'h11223344);
        end
        wr_q.delete();
        done_cyc = -1;
        reload = '{8'h00, 8'h01, 8'h8C, 8'h04, 8'h00, 8'h00};
        last = -1;
        foreach (reload[i]) begin
            send_byte(reload[i], 0, a);
            last = a;
        end
        repeat (3) tick();
        check("reload write_count", wr_q.size(), 1);
        if (wr_q.size() > 0) begin
            check("reload addr", wr_q[0].addr, 0);
            check("reload data", wr_q[0].data, 32'h8C040000);
            check("reload cycle", wr_q[0].cyc, last + 1);
        end
        check("reload done", 32'(done), 32'd1);
        check("reload core_reset", 32'(core_reset), 32'd0);
        check("reload done_cycle", done_cyc, last + 2);
        post_offer("reload");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Boot-time loader upstream of the single-cycle MIPS core. Accepts a program image as a byte stream over a valid/ready handshake, packs bytes into 32-bit big-endian instruction words, and writes them sequentially into instruction memory from word address 0. Holds the core in reset until the whole image is written, so simulations and boards start from a filled instruction memory.

## Interface
- ADDR_WIDTH, 6: instruction-memory word-address width; capacity DEPTH = 2^ADDR_WIDTH words.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- s_valid  in  1  byte on s_data valid.
- s_data  in  8  stream byte.
- s_ready  out  1  loader accepts byte this cycle; transfer = s_valid & s_ready.
- imem_we  out  1  instruction-memory write enable, one-cycle pulse per word.
- imem_addr  out  ADDR_WIDTH  word address of the write.
- imem_wdata  out  32  instruction word.
- core_reset  out  1  reset to the MIPS core; high until load completes.
- done  out  1  image loaded; sticky until reset.
- error  out  1  header word count exceeds DEPTH; sticky until reset.

## Operation
- Clock `clk`; reset is synchronous and active-high, port `reset`.
- Stream format: 2-byte header N (word count, big-endian, high byte first), then 4*N payload bytes; first payload byte of each word → bits [31:24], fourth → [7:0].
- States: LEN_HI, LEN_LO, DATA, FLUSH, DONE, ERROR.
- LEN_HI: s_ready=1; on transfer latch N[15:8] → LEN_LO.
- LEN_LO: s_ready=1; on transfer latch N[7:0], then: N==0 → DONE; N>DEPTH → ERROR; else → DATA with word index 0, byte index 0.
- DATA: s_ready=1; each transfer shifts byte into 32-bit assembly register, byte index mod 4 increments. On 4th byte: register imem_we=1, imem_addr=word index, imem_wdata=assembled word for the next cycle; word index increments. If that word was word N-1 → FLUSH, else stay in DATA (back-to-back bytes allowed, no bubble).
- FLUSH: s_ready=0; final write pulse visible; → DONE.
- DONE: s_ready=0, done=1, core_reset=0; bytes offered are ignored (not accepted).
- ERROR: s_ready=0, error=1, core_reset=1, no writes; exit only by reset.
- N==DEPTH is legal; last write at address DEPTH-1. Word index width ADDR_WIDTH+1 internally; no wrap.
- s_valid low in any state: state and counters hold; partial word retained.
- s_data ignored when no transfer.

## Timing
- Reset values (while reset high and the cycle after): s_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_reset=1, done=0, error=0; state LEN_HI. s_ready=1 from first cycle with reset low.
- s_ready is a function of state only (registered-state decode); never depends on s_valid.
- Write latency: 4th byte of a word accepted at edge t → imem_we=1 in cycle t+1 for exactly one cycle; imem_addr/imem_wdata valid with it, hold last value otherwise.
- Completion (N>0): final byte accepted at t → imem_we at t+1 (FLUSH) → done=1, core_reset=0 at t+2. Core never leaves reset before its last instruction is written.
- N==0: low header byte accepted at t → done=1, core_reset=0 at t+1; no imem_we.
- N>DEPTH: low header byte accepted at t → error=1 at t+1.
- Reset mid-load: aborts at next edge; partial word discarded; words already written stay in memory; core_reset=1; restart at LEN_HI expecting a new header.
- Max throughput: one byte per cycle; N words load in 4N+2 transfer cycles + 2.

## Test plan
- Reset → outputs: hold reset 2 cycles → s_ready=0, core_reset=1, done=0, error=0, imem_we=0; after release s_ready=1.
- 2-word image, back-to-back: bytes 00 02 20 02 00 05 20 03 00 02 → writes (0,0x20020005),(1,0x20030002), one cycle each; done=1, core_reset=0 two cycles after last byte.
- Gapped stream: same image with s_valid low 3 cycles between every byte → identical writes/addresses, no extra imem_we, no lost bytes.
- Header edge cases: N=0 → done next cycle, no writes; N=64 with ADDR_WIDTH=6 → 64 writes, last at addr 63; N=65 → error=1, no writes, core_reset stays 1, s_ready=0.
- Reset mid-load: pulse reset after 6 payload bytes of a 4-word image → word 0 written, word 1 discarded; reload 1-word image 0x8C040000 → write at addr 0, done.
- Post-done stream: offer bytes with s_valid=1 after done → s_ready=0, no imem_we, done stays 1.
